// File: rtl/writeback.sv
// Writeback stage: commits register writes, owns CPSR and the banked SPSRs, and redirects fetch on r15 writes.
// Optional forwarding of the committed write is enabled by defining WRITEBACK_BYPASS_EN.
module writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic        inbubble,
  input  logic        write_reg,
  input  logic [3:0]  write_num,
  input  logic [31:0] write_data,
  input  logic [31:0] cpsr,
  input  logic        cpsrup,
  input  logic [31:0] spsr,
  input  logic        spsrup,
  output logic        rf_write,
  output logic [3:0]  rf_write_num,
  output logic [31:0] rf_write_data,
  output logic [31:0] outcpsr,
  output logic [31:0] outspsr,
  output logic        jmp,
  output logic [31:0] jmppc,
  output logic        flush,
  output logic        fwd_valid,
  output logic [3:0]  fwd_num,
  output logic [31:0] fwd_data
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;
  localparam int unsigned CW = 2;

  localparam logic [RW-1:0] PC_NUM      = RW'(15);
  localparam logic [CW-1:0] SQUASH_LEN  = CW'(2);
  localparam logic [DW-1:0] CPSR_RESET  = DW'(32'h0000_00D3);

  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;

  typedef enum logic {IDLE, SQUASH} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   counter, counter_nxt;
  logic            jmp_nxt, flush_nxt, rf_write_nxt;
  logic [RW-1:0]   rf_write_num_nxt;
  logic [DW-1:0]   rf_write_data_nxt, jmppc_nxt;
  logic            slot_valid_c;
  logic [DW-1:0]   spsr_fiq, spsr_irq, spsr_svc, spsr_abt, spsr_und;

  assign slot_valid_c = !inbubble && (state == IDLE);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      counter       <= '0;
      jmp           <= 1'b0;
      flush         <= 1'b0;
      jmppc         <= '0;
      rf_write      <= 1'b0;
      rf_write_num  <= '0;
      rf_write_data <= '0;
    end else begin
      state         <= state_nxt;
      counter       <= counter_nxt;
      jmp           <= jmp_nxt;
      flush         <= flush_nxt;
      jmppc         <= jmppc_nxt;
      rf_write      <= rf_write_nxt;
      rf_write_num  <= rf_write_num_nxt;
      rf_write_data <= rf_write_data_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt         = state;
    counter_nxt       = counter;
    jmp_nxt           = 1'b0;
    flush_nxt         = 1'b0;
    jmppc_nxt         = jmppc;
    rf_write_nxt      = 1'b0;
    rf_write_num_nxt  = rf_write_num;
    rf_write_data_nxt = rf_write_data;

    if (slot_valid_c && write_reg) begin
      rf_write_nxt      = 1'b1;
      rf_write_num_nxt  = write_num;
      rf_write_data_nxt = write_data;
    end

    case (state)
      IDLE: begin
        if (slot_valid_c && write_reg && (write_num == PC_NUM)) begin
          state_nxt   = SQUASH;
          counter_nxt = SQUASH_LEN;
          jmp_nxt     = 1'b1;
          flush_nxt   = 1'b1;
          jmppc_nxt   = write_data;
        end
      end
      SQUASH: begin
        // Flush holds while counting down; leave the cycle after it hits zero
        if (counter == '0) begin
          state_nxt = IDLE;
        end else begin
          counter_nxt = counter - CW'(1);
          flush_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // CPSR and SPSR banks; the SPSR bank is chosen by the mode before this cycle's CPSR update
  always_ff @(posedge clk) begin
    if (rst) begin
      outcpsr  <= CPSR_RESET;
      spsr_fiq <= '0;
      spsr_irq <= '0;
      spsr_svc <= '0;
      spsr_abt <= '0;
      spsr_und <= '0;
    end else if (slot_valid_c) begin
      if (cpsrup) outcpsr <= cpsr;
      if (spsrup) begin
        case (outcpsr[4:0])
          MODE_FIQ: spsr_fiq <= spsr;
          MODE_IRQ: spsr_irq <= spsr;
          MODE_SVC: spsr_svc <= spsr;
          MODE_ABT: spsr_abt <= spsr;
          MODE_UND: spsr_und <= spsr;
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    outspsr = '0;
    case (outcpsr[4:0])
      MODE_FIQ: outspsr = spsr_fiq;
      MODE_IRQ: outspsr = spsr_irq;
      MODE_SVC: outspsr = spsr_svc;
      MODE_ABT: outspsr = spsr_abt;
      MODE_UND: outspsr = spsr_und;
      default:  outspsr = '0;
    endcase
  end

`ifdef WRITEBACK_BYPASS_EN
  // Forwarding copy of the committed write; PC writes are never forwarded
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_valid <= 1'b0;
      fwd_num   <= '0;
      fwd_data  <= '0;
    end else begin
      fwd_valid <= rf_write_nxt && (rf_write_num_nxt != PC_NUM);
      fwd_num   <= rf_write_num_nxt;
      fwd_data  <= rf_write_data_nxt;
    end
  end
`else
  assign fwd_valid = 1'b0;
  assign fwd_num   = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: directed scenarios then random traffic against a cycle-level reference model.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst, inbubble, write_reg, cpsrup, spsrup;
  logic [3:0]  write_num;
  logic [31:0] write_data, cpsr, spsr;
  logic        rf_write, jmp, flush, fwd_valid;
  logic [3:0]  rf_write_num, fwd_num;
  logic [31:0] rf_write_data, outcpsr, outspsr, jmppc, fwd_data;

  writeback dut (
    .clk(clk), .rst(rst), .inbubble(inbubble), .write_reg(write_reg),
    .write_num(write_num), .write_data(write_data), .cpsr(cpsr), .cpsrup(cpsrup),
    .spsr(spsr), .spsrup(spsrup), .rf_write(rf_write), .rf_write_num(rf_write_num),
    .rf_write_data(rf_write_data), .outcpsr(outcpsr), .outspsr(outspsr), .jmp(jmp),
    .jmppc(jmppc), .flush(flush), .fwd_valid(fwd_valid), .fwd_num(fwd_num), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rf_write;
    logic [3:0]  num;
    logic [31:0] data;
    logic        jmp;
    logic [31:0] jmppc;
    logic        flush;
    logic [31:0] cpsr;
    logic [31:0] spsr;
    logic        fwd_valid;
    logic [3:0]  fnum;
    logic [31:0] fdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model state: slots still to be discarded after a PC write, plus architectural registers
  int          m_squash;
  logic [31:0] m_cpsr, m_jmppc, m_data;
  logic [31:0] m_banks[5];
  logic [3:0]  m_num;
  logic        m_rfw;

  function automatic int bank_idx(input logic [4:0] mode);
    case (mode)
      5'b10001: return 0;
      5'b10010: return 1;
      5'b10011: return 2;
      5'b10111: return 3;
      5'b11011: return 4;
      default:  return -1;
    endcase
  endfunction

  task automatic step(input logic r, input logic b, input logic wr, input logic [3:0] n,
                      input logic [31:0] d, input logic cu, input logic [31:0] c,
                      input logic su, input logic [31:0] s);
    exp_t e;
    logic valid, j;
    int   bi;
    @(negedge clk);
    rst = r; inbubble = b; write_reg = wr; write_num = n; write_data = d;
    cpsrup = cu; cpsr = c; spsrup = su; spsr = s;
    j = 1'b0;
    if (r) begin
      m_squash = 0; m_cpsr = 32'hD3; m_jmppc = 0; m_data = 0; m_num = 0; m_rfw = 0;
      for (int i = 0; i < 5; i++) m_banks[i] = 0;
    end else begin
      valid = !b && (m_squash == 0);
      if (m_squash > 0) m_squash--;
      m_rfw = valid && wr;
      if (m_rfw) begin m_num = n; m_data = d; end
      if (m_rfw && n == 4'd15) begin j = 1'b1; m_jmppc = d; m_squash = 3; end
      bi = bank_idx(m_cpsr[4:0]);
      if (valid && su && bi >= 0) m_banks[bi] = s;
      if (valid && cu) m_cpsr = c;
    end
    bi = bank_idx(m_cpsr[4:0]);
    e.rf_write = m_rfw; e.num = m_num; e.data = m_data;
    e.jmp = j; e.jmppc = m_jmppc; e.flush = (m_squash > 0);
    e.cpsr = m_cpsr; e.spsr = (bi >= 0) ? m_banks[bi] : 32'h0;
`ifdef WRITEBACK_BYPASS_EN
    e.fwd_valid = m_rfw && (m_num != 4'd15); e.fnum = m_num; e.fdata = m_data;
`else
    e.fwd_valid = 1'b0; e.fnum = 4'd0; e.fdata = 32'd0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic wr_reg(input logic [3:0] n, input logic [31:0] d);
    step(0, 0, 1, n, d, 0, 0, 0, 0);
  endtask

  task automatic idle();
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one expected entry per clock edge after stimulus
  always @(posedge clk) begin
    exp_t e, g;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = '{rf_write, rf_write_num, rf_write_data, jmp, jmppc, flush, outcpsr, outspsr,
            fwd_valid, fwd_num, fwd_data};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got rfw=%b n=%0d d=%h jmp=%b pc=%h fl=%b cpsr=%h spsr=%h fv=%b fn=%0d fd=%h exp rfw=%b n=%0d d=%h jmp=%b pc=%h fl=%b cpsr=%h spsr=%h fv=%b fn=%0d fd=%h",
                 cyc, g.rf_write, g.num, g.data, g.jmp, g.jmppc, g.flush, g.cpsr, g.spsr, g.fwd_valid, g.fnum, g.fdata,
                 e.rf_write, e.num, e.data, e.jmp, e.jmppc, e.flush, e.cpsr, e.spsr, e.fwd_valid, e.fnum, e.fdata);
      end
    end
  end

  initial begin
    logic [4:0] modes[8];
    int         waited;
    modes = '{5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10111, 5'b11011, 5'b11111, 5'b00101};
    rst = 1; inbubble = 1; write_reg = 0; write_num = 0; write_data = 0;
    cpsrup = 0; cpsr = 0; spsrup = 0; spsr = 0;

    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 4'd5, 32'hDEAD, 1, 32'h10, 1, 32'h1);
    wr_reg(4'd3, 32'h12345678);
    idle();
    // PC write squashes the next three slots
    wr_reg(4'd15, 32'h100);
    for (int i = 0; i < 4; i++) wr_reg(4'd1, 32'h1000 + i);
    idle();
    // SPSR write uses the pre-update mode
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'hD2, 1, 32'hA0000010);
    idle();
    step(0, 0, 0, 0, 0, 1, 32'hD3, 0, 0);
    // USR mode ignores SPSR writes
    step(0, 0, 0, 0, 0, 1, 32'h10, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF);
    step(0, 0, 0, 0, 0, 1, 32'hD3, 0, 0);
    // Reset aborts a squash
    wr_reg(4'd15, 32'h200);
    step(1, 0, 1, 4'd15, 32'h300, 0, 0, 0, 0);
    wr_reg(4'd2, 32'h22);
    // Exception return: PC write together with CPSR update
    step(0, 0, 1, 4'd15, 32'h400, 1, 32'h12, 0, 0);
    idle(); idle(); idle();
    wr_reg(4'd7, 32'hCAFEF00D);
    wr_reg(4'd15, 32'h500);
    idle(); idle(); idle();

    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)), $urandom(), $urandom_range(0, 3) == 0,
           {$urandom() & 32'hFFFFFFE0} | {27'd0, modes[$urandom_range(0, 7)]},
           $urandom_range(0, 2) == 0, $urandom());
    end
    idle();

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
